// File: rtl/cntr8_updown.sv
// Loadable WIDTH-bit up/down counter with a mode FSM; next count comes from a
// ripple of 4-bit carry-lookahead slices. CNTR8_UPDOWN_SAT_EN selects saturating mode.

module cntr8_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] g, p;
  logic [3:1] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    s    = p ^ {c[3:1], ci};
  end
endmodule

module cntr8_updown #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic [2:0]       o_state,
  output logic             ovf,
  output logic             busy
);
  localparam int NSL = WIDTH / 4;

  localparam logic [2:0] S_IDLE = 3'b000;
  localparam logic [2:0] S_LOAD = 3'b001;
  localparam logic [2:0] S_INC  = 3'b010;
  localparam logic [2:0] S_DEC  = 3'b011;
  localparam logic [2:0] S_HOLD = 3'b100;

  logic [2:0]       state, nxt;
  logic [WIDTH-1:0] b_op, sum, cnt_nxt;
  logic [NSL:0]     c;
  logic             co, ovf_nxt;

  // next-state decode; unreachable codes fall back to IDLE
  always_comb begin
    nxt = S_IDLE;
    if (state > S_HOLD)   nxt = S_IDLE;
    else if (load)        nxt = S_LOAD;
    else if (inc && dec)  nxt = S_HOLD;
    else if (inc)         nxt = S_INC;
    else if (dec)         nxt = S_DEC;
    else                  nxt = S_IDLE;
  end

  // +1 or +all-ones (i.e. -1), carry-in 0, nibble carries rippled slice to slice
  assign b_op = (nxt == S_DEC) ? {WIDTH{1'b1}} : {{(WIDTH-1){1'b0}}, 1'b1};
  assign c[0] = 1'b0;

  for (genvar k = 0; k < NSL; k++) begin : g_slice
    cntr8_cla4 u_cla (
      .a  (d_out[4*k +: 4]),
      .b  (b_op[4*k +: 4]),
      .ci (c[k]),
      .s  (sum[4*k +: 4]),
      .co (c[k+1])
    );
  end

  assign co = c[NSL];

  always_comb begin
    ovf_nxt = ((nxt == S_INC) && co) || ((nxt == S_DEC) && !co);
    cnt_nxt = d_out;
    case (nxt)
      S_LOAD: cnt_nxt = d_in;
`ifdef CNTR8_UPDOWN_SAT_EN
      S_INC:  cnt_nxt = co  ? d_out : sum;
      S_DEC:  cnt_nxt = !co ? d_out : sum;
`else
      S_INC:  cnt_nxt = sum;
      S_DEC:  cnt_nxt = sum;
`endif
      default: cnt_nxt = d_out;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      d_out <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= nxt;
      d_out <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

  always_comb begin
    o_state = state;
    busy    = (state != S_IDLE);
  end
endmodule

// File: tb/tb_cntr8_updown.sv
// Scoreboard bench for cntr8_updown: stimulus pushes hand-computed expectations,
// monitors pop and compare after each clock edge or on an async-reset strobe.

module tb_cntr8_updown;
  logic       clk = 1'b0;
  logic       reset_n, load, inc, dec;
  logic [7:0] d_in, d_out;
  logic [2:0] o_state;
  logic       ovf, busy;
  logic       astrobe = 1'b0;

  typedef struct {
    int         id;
    logic [7:0] d;
    logic [2:0] st;
    logic       ovf;
    logic       busy;
  } exp_t;

  exp_t q[$];
  exp_t aq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int vec_id = 0;

  cntr8_updown #(.WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .inc(inc), .dec(dec),
    .d_in(d_in), .d_out(d_out), .o_state(o_state), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int id, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %h want %h", nm, id, act, exp);
    end
  endtask

  task automatic check_all(input exp_t e);
    chk("d_out",   e.id, d_out, e.d);
    chk("o_state", e.id, {5'b0, o_state}, {5'b0, e.st});
    chk("ovf",     e.id, {7'b0, ovf}, {7'b0, e.ovf});
    chk("busy",    e.id, {7'b0, busy}, {7'b0, e.busy});
  endtask

  // one cycle of stimulus; expectation applies after the following rising edge
  task automatic cyc(input logic rst, input logic ld, input logic up, input logic dn,
                     input logic [7:0] din, input logic [7:0] ed, input logic [2:0] es,
                     input logic eo);
    exp_t e;
    @(negedge clk);
    reset_n = rst; load = ld; inc = up; dec = dn; d_in = din;
    e.id = vec_id++; e.d = ed; e.st = es; e.ovf = eo; e.busy = (es != 3'b000);
    q.push_back(e);
  endtask

  initial begin : mon_clk
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check_all(e);
      end
    end
  end

  initial begin : mon_async
    exp_t e;
    forever begin
      @(posedge astrobe);
      if (aq.size() > 0) begin
        e = aq.pop_front();
        check_all(e);
      end
    end
  end

  initial begin : stim
    exp_t e;
    reset_n = 1'b0; load = 1'b0; inc = 1'b0; dec = 1'b0; d_in = 8'h00;
    // reset held with inc toggling
    cyc(0, 0, 1, 0, 8'h00, 8'h00, 3'b000, 0);
    cyc(0, 0, 0, 0, 8'h00, 8'h00, 3'b000, 0);
    cyc(0, 0, 1, 0, 8'h00, 8'h00, 3'b000, 0);
    cyc(1, 0, 1, 0, 8'h00, 8'h01, 3'b010, 0);
    cyc(1, 0, 1, 0, 8'h00, 8'h02, 3'b010, 0);
    cyc(1, 0, 1, 0, 8'h00, 8'h03, 3'b010, 0);
    // load FE and count up through the wrap
    cyc(1, 1, 0, 0, 8'hFE, 8'hFE, 3'b001, 0);
    cyc(1, 0, 1, 0, 8'h00, 8'hFF, 3'b010, 0);
`ifdef CNTR8_UPDOWN_SAT_EN
    cyc(1, 0, 1, 0, 8'h00, 8'hFF, 3'b010, 1);
    cyc(1, 0, 1, 0, 8'h00, 8'hFF, 3'b010, 1);
`else
    cyc(1, 0, 1, 0, 8'h00, 8'h00, 3'b010, 1);
    cyc(1, 0, 1, 0, 8'h00, 8'h01, 3'b010, 0);
`endif
    // load 01 and count down through zero
    cyc(1, 1, 0, 0, 8'h01, 8'h01, 3'b001, 0);
    cyc(1, 0, 0, 1, 8'h00, 8'h00, 3'b011, 0);
`ifdef CNTR8_UPDOWN_SAT_EN
    cyc(1, 0, 0, 1, 8'h00, 8'h00, 3'b011, 1);
`else
    cyc(1, 0, 0, 1, 8'h00, 8'hFF, 3'b011, 1);
`endif
    // priority: load over inc/dec, then hold, then idle
    cyc(1, 1, 1, 1, 8'h5A, 8'h5A, 3'b001, 0);
    cyc(1, 0, 1, 1, 8'h00, 8'h5A, 3'b100, 0);
    cyc(1, 0, 0, 0, 8'h00, 8'h5A, 3'b000, 0);
    // nibble carry and borrow across the slice boundary
    cyc(1, 1, 0, 0, 8'h0F, 8'h0F, 3'b001, 0);
    cyc(1, 0, 1, 0, 8'h00, 8'h10, 3'b010, 0);
    cyc(1, 1, 0, 0, 8'h10, 8'h10, 3'b001, 0);
    cyc(1, 0, 0, 1, 8'h00, 8'h0F, 3'b011, 0);
    // loading boundary values never flags ovf, even with inc/dec asserted
    cyc(1, 1, 1, 0, 8'hFF, 8'hFF, 3'b001, 0);
    cyc(1, 1, 0, 1, 8'h00, 8'h00, 3'b001, 0);
    cyc(1, 0, 0, 0, 8'h00, 8'h00, 3'b000, 0);
    // async reset mid-count
    cyc(1, 1, 0, 0, 8'h36, 8'h36, 3'b001, 0);
    cyc(1, 0, 1, 0, 8'h00, 8'h37, 3'b010, 0);
    @(negedge clk);
    inc = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    e.id = vec_id++; e.d = 8'h00; e.st = 3'b000; e.ovf = 1'b0; e.busy = 1'b0;
    aq.push_back(e);
    astrobe = 1'b1;
    #1;
    astrobe = 1'b0;
    cyc(0, 0, 1, 0, 8'h00, 8'h00, 3'b000, 0);
    cyc(0, 0, 1, 0, 8'h00, 8'h00, 3'b000, 0);
    cyc(1, 0, 1, 0, 8'h00, 8'h01, 3'b010, 0);
    cyc(1, 0, 0, 0, 8'h00, 8'h01, 3'b000, 0);

    for (int i = 0; i < 10 && (q.size() > 0 || aq.size() > 0); i++) @(posedge clk);
    #2;
    if (q.size() > 0 || aq.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size() + aq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
